// File: rtl/riscv_pkg.sv
// Shared types and defaults for the front-end pipeline (IF/ID).
package riscv_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  // IF -> ID pipeline register contents.
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
  } if_id_reg_t;

  // Entry stored by fetch_fifo; the PC queue leaves instr unused.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned.
  function automatic logic [63:0] align_word(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of {pc, instr} entries with synchronous clear and occupancy count.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  fetch_entry_t               data_i,
  input  logic                       pop_i,
  output fetch_entry_t               data_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_eff, pop_eff;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_q];

  // A full FIFO may still accept a push when it is popped in the same cycle.
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_eff) wr_d = (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + PtrW'(1);
    if (pop_eff)  rd_d = (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + PtrW'(1);
    if (push_eff && !pop_eff) count_d = count_q + CntW'(1);
    if (!push_eff && pop_eff) count_d = count_q - CntW'(1);
  end

  // Control state; clear behaves like reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage array, no reset needed: entries are only read when counted valid.
  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_q] <= data_i;
  end

  // The producer's credit scheme must never push into a full FIFO.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i && !clear_i));

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order PC tagging,
// stall buffering and redirect with discard of stale responses.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [63:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output if_id_reg_t  if_id_reg
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  logic [63:0]     pc_q, pc_d;
  logic [CntW-1:0] discard_q, discard_d;
  if_id_reg_t      if_id_q, if_id_d;

  fetch_entry_t    pcq_head, rsp_head, pcq_in, rsp_in;
  logic [CntW-1:0] pcq_count, rsp_count;
  logic            pcq_empty, pcq_full, rsp_empty, rsp_full;
  logic            fire, credit_ok, rsp_keep, rsp_push, rsp_pop;
  logic            unused_sig;

  // pcq_count is every request still in flight, including ones to be discarded.
  assign credit_ok      = (32'(pcq_count) + 32'(rsp_count)) < MAX_OUTSTANDING;
  assign imem_req_valid = rst_n && !redirect && (discard_q == '0) && credit_ok;
  assign imem_req_addr  = align_word(pc_q);
  assign fire           = imem_req_valid && imem_req_ready;

  // A response is kept only if it is not being flushed by a past or current redirect.
  assign rsp_keep = rst_n && imem_rsp_valid && (discard_q == '0) && !redirect;
  assign rsp_pop  = !stall && !redirect && !rsp_empty;
  assign rsp_push = rsp_keep && (stall || !rsp_empty);

  assign pcq_in = '{pc: imem_req_addr, instr: '0};
  assign rsp_in = '{pc: pcq_head.pc, instr: imem_rsp_data};

  fetch_fifo #(
    .Depth(MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clear_i(1'b0),
    .push_i (fire),
    .data_i (pcq_in),
    .pop_i  (imem_rsp_valid),
    .data_o (pcq_head),
    .count_o(pcq_count),
    .empty_o(pcq_empty),
    .full_o (pcq_full)
  );

  fetch_fifo #(
    .Depth(MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clear_i(redirect),
    .push_i (rsp_push),
    .data_i (rsp_in),
    .pop_i  (rsp_pop),
    .data_o (rsp_head),
    .count_o(rsp_count),
    .empty_o(rsp_empty),
    .full_o (rsp_full)
  );

  assign unused_sig = ^{pcq_head.instr, pcq_full, rsp_full, pcq_empty};

  // Next fetch PC, discard counter and IF/ID register contents.
  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    if_id_d   = if_id_q;

    if (redirect)  pc_d = redirect_pc;
    else if (fire) pc_d = pc_q + 64'd4;

    if (redirect) begin
      // Everything still in flight becomes stale, minus a response landing now.
      discard_d = pcq_count - CntW'(imem_rsp_valid && (pcq_count != '0));
    end else if (imem_rsp_valid && (discard_q != '0)) begin
      discard_d = discard_q - CntW'(1);
    end

    if (redirect) begin
      if_id_d = '0;
    end else if (!stall) begin
      if (!rsp_empty) begin
        if_id_d = '{valid: 1'b1, pc: rsp_head.pc, instr: rsp_head.instr};
      end else if (rsp_keep) begin
        if_id_d = '{valid: 1'b1, pc: pcq_head.pc, instr: imem_rsp_data};
      end else begin
        if_id_d = '0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
      if_id_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
      if_id_q   <= if_id_d;
    end
  end

  assign if_id_reg = if_id_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; the memory side is driven step by step by hand.
module tb_if_stage;
  import riscv_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [63:0] redirect_pc, imem_req_addr;
  logic [31:0] imem_rsp_data;
  if_id_reg_t  if_id_reg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC       (RST_PC),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .if_id_reg     (if_id_reg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [63:0] pc,
                          input logic [31:0] instr);
    chk({tag, ".valid"}, 64'(if_id_reg.valid), 64'(v));
    chk({tag, ".pc"}, if_id_reg.pc, pc);
    chk({tag, ".instr"}, 64'(if_id_reg.instr), 64'(instr));
  endtask

  // Advance past the next rising edge; outputs are then sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    cyc(); cyc();
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk_ifid("rst_ifid", 1'b0, 64'd0, 32'd0);
    chk("rst_pc", dut.pc_q, RST_PC);

    // Streaming fetch with a 1-cycle memory.
    rst_n = 1'b1; #1;
    chk("s0_valid", 64'(imem_req_valid), 64'd1);
    chk("s0_addr", imem_req_addr, 64'h8000_0000);
    cyc();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013; #1;
    chk("s1_addr", imem_req_addr, 64'h8000_0004);
    cyc();
    chk_ifid("s1_ifid", 1'b1, 64'h8000_0000, 32'h0000_0013);
    imem_rsp_data = 32'h0010_0093; #1;
    chk("s2_addr", imem_req_addr, 64'h8000_0008);
    cyc();
    chk_ifid("s2_ifid", 1'b1, 64'h8000_0004, 32'h0010_0093);

    // Stall with two fetches in flight.
    imem_rsp_valid = 1'b0; stall = 1'b1; #1;
    chk("st0_valid", 64'(imem_req_valid), 64'd1);
    chk("st0_addr", imem_req_addr, 64'h8000_000C);
    cyc();
    chk("st0_inflight", 64'(dut.u_pc_queue.count_o), 64'd2);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_0113; #1;
    chk("st1_valid", 64'(imem_req_valid), 64'd0);
    cyc();
    imem_rsp_data = 32'h0030_0193; #1;
    chk("st2_valid", 64'(imem_req_valid), 64'd0);
    cyc();
    chk("st2_fifo", 64'(dut.u_rsp_fifo.count_o), 64'd2);
    chk_ifid("st2_hold", 1'b1, 64'h8000_0004, 32'h0010_0093);
    imem_rsp_valid = 1'b0; #1;
    chk("st3_valid", 64'(imem_req_valid), 64'd0);
    cyc();
    chk_ifid("st3_hold", 1'b1, 64'h8000_0004, 32'h0010_0093);
    stall = 1'b0; #1;
    chk("rel0_valid", 64'(imem_req_valid), 64'd0);
    cyc();
    chk_ifid("rel0_ifid", 1'b1, 64'h8000_0008, 32'h0020_0113);
    #1;
    chk("rel1_valid", 64'(imem_req_valid), 64'd1);
    chk("rel1_addr", imem_req_addr, 64'h8000_0010);
    cyc();
    chk_ifid("rel1_ifid", 1'b1, 64'h8000_000C, 32'h0030_0193);
    chk("rel1_fifo", 64'(dut.u_rsp_fifo.count_o), 64'd0);
    #1;
    chk("rel2_addr", imem_req_addr, 64'h8000_0014);
    cyc();
    chk("rel2_ifid_valid", 64'(if_id_reg.valid), 64'd0);

    // Redirect with two responses outstanding.
    redirect = 1'b1; redirect_pc = 64'h8000_1000; #1;
    chk("rd0_valid", 64'(imem_req_valid), 64'd0);
    cyc();
    chk("rd0_ifid_valid", 64'(if_id_reg.valid), 64'd0);
    chk("rd0_discard", 64'(dut.discard_q), 64'd2);
    chk("rd0_pc", dut.pc_q, 64'h8000_1000);
    redirect = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0001; #1;
    chk("rd1_valid", 64'(imem_req_valid), 64'd0);
    cyc();
    chk("rd1_ifid_valid", 64'(if_id_reg.valid), 64'd0);
    chk("rd1_discard", 64'(dut.discard_q), 64'd1);
    imem_rsp_data = 32'hDEAD_0002; #1;
    chk("rd2_valid", 64'(imem_req_valid), 64'd0);
    cyc();
    chk("rd2_ifid_valid", 64'(if_id_reg.valid), 64'd0);
    chk("rd2_discard", 64'(dut.discard_q), 64'd0);
    imem_rsp_valid = 1'b0; #1;
    chk("rd3_valid", 64'(imem_req_valid), 64'd1);
    chk("rd3_addr", imem_req_addr, 64'h8000_1000);
    cyc();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0040_0213; #1;
    chk("rd4_addr", imem_req_addr, 64'h8000_1004);
    cyc();
    chk_ifid("rd4_ifid", 1'b1, 64'h8000_1000, 32'h0040_0213);

    // Redirect and response together while stalled: response is dropped.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 64'h8000_0FFE;
    imem_rsp_data = 32'hBAD0_0BAD; #1;
    chk("rs_valid", 64'(imem_req_valid), 64'd0);
    cyc();
    chk("rs_ifid_valid", 64'(if_id_reg.valid), 64'd0);
    chk("rs_discard", 64'(dut.discard_q), 64'd0);
    chk("rs_fifo", 64'(dut.u_rsp_fifo.count_o), 64'd0);
    chk("rs_inflight", 64'(dut.u_pc_queue.count_o), 64'd0);

    // Unaligned redirect target and 64-bit wrap.
    stall = 1'b0; redirect = 1'b0; imem_rsp_valid = 1'b0; #1;
    chk("al_valid", 64'(imem_req_valid), 64'd1);
    chk("al_addr", imem_req_addr, 64'h8000_0FFC);
    cyc();
    chk("al_ifid_valid", 64'(if_id_reg.valid), 64'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0293; #1;
    chk("al2_addr", imem_req_addr, 64'h8000_1000);
    cyc();
    chk_ifid("al2_ifid", 1'b1, 64'h8000_0FFC, 32'h0050_0293);
    imem_rsp_valid = 1'b0; redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc();
    chk("wr0_discard", 64'(dut.discard_q), 64'd1);
    redirect = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0003; #1;
    chk("wr1_valid", 64'(imem_req_valid), 64'd0);
    cyc();
    chk("wr1_ifid_valid", 64'(if_id_reg.valid), 64'd0);
    imem_rsp_valid = 1'b0; #1;
    chk("wr2_valid", 64'(imem_req_valid), 64'd1);
    chk("wr2_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc();
    chk("wr2_pc", dut.pc_q, 64'd0);
    #1;
    chk("wr3_valid", 64'(imem_req_valid), 64'd1);
    chk("wr3_addr", imem_req_addr, 64'd0);
    cyc();
    chk("wr3_inflight", 64'(dut.u_pc_queue.count_o), 64'd2);

    // Reset mid-stream with two outstanding.
    rst_n = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0004; #1;
    chk("mr_valid", 64'(imem_req_valid), 64'd0);
    cyc();
    chk_ifid("mr_ifid", 1'b0, 64'd0, 32'd0);
    chk("mr_inflight", 64'(dut.u_pc_queue.count_o), 64'd0);
    chk("mr_fifo", 64'(dut.u_rsp_fifo.count_o), 64'd0);
    chk("mr_discard", 64'(dut.discard_q), 64'd0);
    chk("mr_pc", dut.pc_q, RST_PC);
    rst_n = 1'b1; imem_rsp_valid = 1'b0; #1;
    chk("mr2_valid", 64'(imem_req_valid), 64'd1);
    chk("mr2_addr", imem_req_addr, 64'h8000_0000);
    cyc();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0060_0313;
    cyc();
    chk_ifid("mr3_ifid", 1'b1, 64'h8000_0000, 32'h0060_0313);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, maximum in-flight plus buffered fetches.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port stall  input  1  hold if_id_reg; decode cannot accept.
REQ-006 SHALL have port redirect  input  1  taken branch or jump resolved in EX (branch_taken | jump).
REQ-007 SHALL have port redirect_pc  input  64  new fetch PC (branch_target or jalr_target, selected by top).
REQ-008 SHALL have port imem_req_valid  output  1  fetch request.
REQ-009 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-010 SHALL have port imem_req_addr  output  64  fetch address, 4-byte aligned.
REQ-011 SHALL have port imem_rsp_valid  input  1  instruction returned, in request order, no backpressure.
REQ-012 SHALL have port imem_rsp_data  input  32  instruction word.
REQ-013 SHALL have port if_id_reg  output  if_id_reg_t  {valid, pc[63:0], instr[31:0]} to ID.

Function
REQ-014 SHALL fire a request when imem_req_valid && imem_req_ready; on fire, fetch PC <= PC + 4 (64-bit wrap, no carry out).
REQ-015 SHALL assert imem_req_valid only when outstanding + fifo_count < MAX_OUTSTANDING and redirect is low; valid need not hold across cycles.
REQ-016 SHALL drive imem_req_addr = fetch PC with bits [1:0] forced to 0.
REQ-017 SHALL tag each fired request with its PC in an in-order PC queue (depth MAX_OUTSTANDING); each response pops the queue.
REQ-018 SHALL, when stall low, load if_id_reg from FIFO head if non-empty, else directly from a response arriving this cycle, else valid = 0; latency response-to-if_id_reg = 1 cycle.
REQ-019 SHALL, when stall high, hold if_id_reg unchanged and push arriving responses into the FIFO.
REQ-020 SHALL never overflow the FIFO; the credit rule in REQ-015 guarantees space; overflow is a design error flagged by assertion.
REQ-021 SHALL, on redirect, at the next edge: fetch PC <= redirect_pc, FIFO cleared, if_id_reg.valid <= 0, discard_count <= outstanding responses not yet returned (excluding one arriving in the redirect cycle, which is itself dropped).
REQ-022 SHALL drop responses while discard_count > 0, decrementing per response; imem_req_valid stays low until discard_count reaches 0.
REQ-023 SHALL give redirect priority over stall: redirect with stall high still invalidates if_id_reg.
REQ-024 SHALL handle redirect during discard: discard_count <= current discard_count + outstanding non-discarded, minus any response arriving that cycle.
REQ-025 SHALL count outstanding: +1 on fire, -1 on response, unchanged when both occur.

Reset
REQ-026 SHALL, while rst_n low at a clock edge: fetch PC = RESET_PC, outstanding = 0, discard_count = 0, FIFO empty, PC queue empty, if_id_reg = all zeros.
REQ-027 SHALL drive imem_req_valid = 0 while rst_n low; first request with address RESET_PC in the first cycle rst_n is high.
REQ-028 SHALL treat reset mid-operation as abandoning in-flight responses; the memory side is reset by the same rst_n.

Structure
REQ-029 SHALL take if_id_reg_t and RESET_PC default value from riscv_pkg (shared with id_stage).
REQ-030 SHALL instantiate one sub-module fetch_fifo (parameterised depth, entries {pc, instr}, push/pop/clear, count), used for both response buffer and PC queue.

Verification
REQ-031 Reset release, ready=1, 1-cycle memory -> addrs 0x80000000, 0x80000004, 0x80000008 on consecutive cycles; if_id_reg.pc follows one cycle after each response.
REQ-032 stall high 4 cycles with 2 fetches in flight -> if_id_reg held, FIFO reaches 2, req_valid low; stall release -> buffered instrs emerge in order, no loss or duplication.
REQ-033 redirect to 0x80001000 with 2 responses outstanding -> both dropped, if_id_reg.valid=0 next cycle, next request addr 0x80001000 only after discard_count=0.
REQ-034 redirect and response in same cycle with stall high -> response dropped, if_id_reg.valid=0, no stale instruction reaches ID.
REQ-035 redirect_pc = 0x80000FFE -> imem_req_addr = 0x80000FFC; fetch PC 0xFFFFFFFFFFFFFFFC fires -> next addr 0x0.
REQ-036 rst_n low mid-stream with 2 outstanding -> all outputs at reset values next edge, restart at RESET_PC.
